exposure_ctrl: RTL and testbench
================================

EXPOSURE_CTRL -- requirements
Module: exposure_ctrl

Interface
REQ-001 Parameter EXP_MIN, default 2, lowest exposure count written to Initial.
REQ-002 Parameter EXP_MAX, default 30, highest exposure count written to Initial (SHALL be at most 31).
REQ-003 Parameter EXP_DEFAULT, default 2, exposure count loaded at reset.
REQ-004 Parameter TIMEOUT_CYCLES, default 40, exposure watchdog limit (used only with EXPOSE_TIMEOUT_EN).
REQ-005 Clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-006 Reset  in  1  synchronous, active-low reset.
REQ-007 Init  in  1  request to start one capture cycle.
REQ-008 Exp_increase  in  1  raise exposure count by 1 per cycle while high.
REQ-009 Exp_decrease  in  1  lower exposure count by 1 per cycle while high.
REQ-010 Ovf5  in  1  exposure-done flag from the downstream timer counter.
REQ-011 Start  out  1  one-cycle pulse that restarts the timer counter.
REQ-012 Initial  out  5  exposure count consumed by the timer counter.
REQ-013 Erase  out  1  pixel erase, high in IDLE only.
REQ-014 Expose  out  1  pixel expose, high in EXPOSE only.
REQ-015 NRE_1  out  1  row-1 read enable, active-low.
REQ-016 NRE_2  out  1  row-2 read enable, active-low.
REQ-017 ADC  out  1  ADC sample strobe.

Function
REQ-018 The FSM SHALL have exactly three states: IDLE, EXPOSE and READOUT.
REQ-019 All outputs SHALL be registered.
REQ-020 In IDLE, Initial SHALL follow this table per cycle, with saturation and no wrap:
- Exp_increase=1, Exp_decrease=0: Initial+1, saturating at EXP_MAX.
- Exp_increase=0, Exp_decrease=1: Initial-1, saturating at EXP_MIN.
- Both high, or both low: no change.
REQ-021 In IDLE with Init=1, the FSM SHALL enter EXPOSE on the next edge, and adjust inputs SHALL be ignored in that cycle.
REQ-022 On entering EXPOSE, the FSM SHALL set Start=1 for exactly the first EXPOSE cycle, Expose=1 and Erase=0.
REQ-023 In EXPOSE, Ovf5=1 SHALL move the FSM to READOUT on the next edge, except in the cycle where Start=1, when Ovf5 SHALL be ignored.
REQ-024 Initial SHALL be frozen outside IDLE, and adjust inputs there SHALL be ignored.
REQ-025 Init SHALL be ignored in EXPOSE and in READOUT.
REQ-026 Ovf5 SHALL be ignored in IDLE and in READOUT.
REQ-027 READOUT SHALL last exactly 6 cycles (R0..R5), counted by a 3-bit step counter, with outputs:
- R0: NRE_1=0, ADC=0.
- R1: NRE_1=0, ADC=1.
- R2: NRE_1=1, ADC=0.
- R3: NRE_2=0, ADC=0.
- R4: NRE_2=0, ADC=1.
- R5: NRE_2=1, ADC=0.
REQ-028 After R5, the FSM SHALL return to IDLE with Erase=1.
REQ-029 Outside READOUT, NRE_1=NRE_2=1 and ADC=0.
REQ-030 Expose and Erase SHALL never be high simultaneously.
REQ-031 Expose SHALL never be high together with NRE_1=0 or NRE_2=0.

Reset
REQ-032 Reset=0 at a rising edge SHALL, in any state and regardless of other inputs, force the following on that edge:
- state=IDLE, step counter=0.
- Initial=EXP_DEFAULT.
- Erase=1, Expose=0, Start=0, NRE_1=1, NRE_2=1, ADC=0.
REQ-033 Reset asserted mid-EXPOSE or mid-READOUT SHALL abort the capture with no further Start, ADC or NRE_x activity.
REQ-034 The first edge with Reset=1 SHALL evaluate inputs normally.

Configuration
REQ-035 Macro EXPOSE_TIMEOUT_EN defined:
- A watchdog counter SHALL count EXPOSE cycles.
- If it reaches TIMEOUT_CYCLES without Ovf5, the FSM SHALL enter READOUT exactly as if Ovf5 had arrived.
- The counter SHALL clear on every EXPOSE entry.
REQ-036 Macro EXPOSE_TIMEOUT_EN undefined: no watchdog logic, and EXPOSE SHALL wait for Ovf5 indefinitely.

Verification
REQ-037 Reset=0 for 2 cycles, then Reset=1:
- Required response: Initial=2, Erase=1, NRE_1=NRE_2=1, ADC=0, Start=0, state IDLE.
REQ-038 Saturation at both limits:
- Exp_increase=1 for 40 cycles in IDLE -> Initial steps 2,3,...,30 and holds at 30.
- Then Exp_decrease=1 for 40 cycles -> Initial holds at 2.
- Both adjust inputs high -> Initial unchanged.
REQ-039 Full capture:
- Init pulse -> one-cycle Start and Expose=1.
- Ovf5=1 five cycles later -> Expose=0 next edge.
- Exact NRE_1/ADC/NRE_2/ADC 6-cycle sequence, then Erase=1.
REQ-040 Ignored inputs:
- Init and Exp_increase during EXPOSE/READOUT -> no restart, Initial unchanged.
- Ovf5 in the Start cycle or in IDLE -> no transition.
REQ-041 Reset=0 at R1 of READOUT -> next edge NRE_1=1, ADC=0, IDLE, Initial=2.
REQ-042 With EXPOSE_TIMEOUT_EN and Ovf5 held 0 -> READOUT entered after 40 EXPOSE cycles; without the macro -> FSM stays in EXPOSE for 200+ cycles.

Source files
------------

// File: rtl/exposure_ctrl.sv
// Pixel capture sequencer: IDLE (erase, exposure adjust) -> EXPOSE -> 6-step READOUT.
// Optional exposure watchdog enabled by defining EXPOSE_TIMEOUT_EN.
module exposure_ctrl #(
    parameter int unsigned EXP_MIN        = 2,
    parameter int unsigned EXP_MAX        = 30,
    parameter int unsigned EXP_DEFAULT    = 2,
    parameter int unsigned TIMEOUT_CYCLES = 40
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Init,
    input  logic       Exp_increase,
    input  logic       Exp_decrease,
    input  logic       Ovf5,
    output logic       Start,
    output logic [4:0] Initial,
    output logic       Erase,
    output logic       Expose,
    output logic       NRE_1,
    output logic       NRE_2,
    output logic       ADC
);

    typedef enum logic [1:0] {IDLE, EXPOSE, READOUT} state_t;

    localparam logic [4:0] EXP_MIN_C = 5'(EXP_MIN);
    localparam logic [4:0] EXP_MAX_C = 5'(EXP_MAX);
    localparam logic [4:0] EXP_DEF_C = 5'(EXP_DEFAULT);

    state_t     state_q, state_d;
    logic [2:0] step_q, step_d;
    logic [4:0] initial_q, initial_d;
    logic       start_q, start_d;
    logic       erase_q, expose_q, nre1_q, nre2_q, adc_q;
    logic       timeout_hit;

`ifdef EXPOSE_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] wd_q, wd_d;

    // Counter sits at zero outside EXPOSE, so every entry starts a fresh count.
    always_comb begin
        wd_d        = (state_q == EXPOSE) ? wd_q + 1'b1 : '0;
        timeout_hit = (state_q == EXPOSE) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge Clk) begin
        if (!Reset) wd_q <= '0;
        else        wd_q <= wd_d;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        step_d    = step_q;
        initial_d = initial_q;
        start_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (Init) begin
                    state_d = EXPOSE;
                    start_d = 1'b1;
                end else if (Exp_increase && !Exp_decrease && initial_q < EXP_MAX_C) begin
                    initial_d = initial_q + 5'd1;
                end else if (Exp_decrease && !Exp_increase && initial_q > EXP_MIN_C) begin
                    initial_d = initial_q - 5'd1;
                end
            end
            EXPOSE: begin
                // Ovf5 during the Start cycle is the timer's stale flag, not a real expiry.
                if ((Ovf5 && !start_q) || timeout_hit) begin
                    state_d = READOUT;
                    step_d  = 3'd0;
                end
            end
            READOUT: begin
                if (step_q == 3'd5) begin
                    state_d = IDLE;
                    step_d  = 3'd0;
                end else begin
                    step_d = step_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
                step_d  = 3'd0;
            end
        endcase
    end

    // Outputs are decoded from the next state so they line up with the registered state.
    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q   <= IDLE;
            step_q    <= 3'd0;
            initial_q <= EXP_DEF_C;
            start_q   <= 1'b0;
            erase_q   <= 1'b1;
            expose_q  <= 1'b0;
            nre1_q    <= 1'b1;
            nre2_q    <= 1'b1;
            adc_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            step_q    <= step_d;
            initial_q <= initial_d;
            start_q   <= start_d;
            erase_q   <= (state_d == IDLE);
            expose_q  <= (state_d == EXPOSE);
            nre1_q    <= !((state_d == READOUT) && (step_d == 3'd0 || step_d == 3'd1));
            nre2_q    <= !((state_d == READOUT) && (step_d == 3'd3 || step_d == 3'd4));
            adc_q     <= (state_d == READOUT) && (step_d == 3'd1 || step_d == 3'd4);
        end
    end

    assign Start   = start_q;
    assign Initial = initial_q;
    assign Erase   = erase_q;
    assign Expose  = expose_q;
    assign NRE_1   = nre1_q;
    assign NRE_2   = nre2_q;
    assign ADC     = adc_q;

endmodule

// File: tb/tb_exposure_ctrl.sv
// Directed bench for exposure_ctrl: reset, saturation, full capture, ignored inputs, reset abort, watchdog.
module tb_exposure_ctrl;

    logic       Clk = 1'b0;
    logic       Reset, Init, Exp_increase, Exp_decrease, Ovf5;
    logic       Start, Erase, Expose, NRE_1, NRE_2, ADC;
    logic [4:0] Initial;

    int errors = 0;
    int checks = 0;

    exposure_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Init(Init), .Exp_increase(Exp_increase),
        .Exp_decrease(Exp_decrease), .Ovf5(Ovf5), .Start(Start), .Initial(Initial),
        .Erase(Erase), .Expose(Expose), .NRE_1(NRE_1), .NRE_2(NRE_2), .ADC(ADC)
    );

    always #5 Clk = ~Clk;

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    // Packed {Start, Expose, Erase, NRE_1, NRE_2, ADC}
    function automatic logic [7:0] ctl();
        return {2'b00, Start, Expose, Erase, NRE_1, NRE_2, ADC};
    endfunction

    localparam logic [7:0] C_IDLE = 8'b00_0_0_1_1_1_0;
    localparam logic [7:0] C_EXPS = 8'b00_1_1_0_1_1_0;
    localparam logic [7:0] C_EXP  = 8'b00_0_1_0_1_1_0;

    logic [7:0] ro_exp [6];
    logic [4:0] exp_init;

    initial begin
        ro_exp[0] = 8'b00_0_0_0_0_1_0;
        ro_exp[1] = 8'b00_0_0_0_0_1_1;
        ro_exp[2] = 8'b00_0_0_0_1_1_0;
        ro_exp[3] = 8'b00_0_0_0_1_0_0;
        ro_exp[4] = 8'b00_0_0_0_1_0_1;
        ro_exp[5] = 8'b00_0_0_0_1_1_0;

        Reset = 1'b0; Init = 1'b1; Exp_increase = 1'b1; Exp_decrease = 1'b0; Ovf5 = 1'b1;
        tick(); tick();
        check("reset_ctl", ctl(), C_IDLE);
        check("reset_initial", 8'(Initial), 8'd2);
        Init = 1'b0; Exp_increase = 1'b0; Ovf5 = 1'b0; Reset = 1'b1;
        tick();
        check("post_reset_ctl", ctl(), C_IDLE);
        check("post_reset_initial", 8'(Initial), 8'd2);

        // Saturation at both limits
        exp_init = 5'd2;
        Exp_increase = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (exp_init < 5'd30) exp_init = exp_init + 5'd1;
            check("inc_sat", 8'(Initial), 8'(exp_init));
        end
        check("inc_hold30", 8'(Initial), 8'd30);
        Exp_increase = 1'b0; Exp_decrease = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (exp_init > 5'd2) exp_init = exp_init - 5'd1;
            check("dec_sat", 8'(Initial), 8'(exp_init));
        end
        check("dec_hold2", 8'(Initial), 8'd2);
        Exp_decrease = 1'b0; Exp_increase = 1'b1;
        tick(); tick(); tick();
        check("inc_to5", 8'(Initial), 8'd5);
        Exp_decrease = 1'b1;
        tick(); tick();
        check("both_high", 8'(Initial), 8'd5);
        Exp_increase = 1'b0; Exp_decrease = 1'b0; Ovf5 = 1'b1;
        tick();
        check("ovf_in_idle", ctl(), C_IDLE);
        Ovf5 = 1'b0;

        // Full capture; adjust input ignored on the Init cycle
        Init = 1'b1; Exp_increase = 1'b1;
        tick();
        check("start_cycle", ctl(), C_EXPS);
        check("init_cycle_initial", 8'(Initial), 8'd5);
        Init = 1'b0; Ovf5 = 1'b1;
        tick();
        check("ovf_in_start_ignored", ctl(), C_EXP);
        Ovf5 = 1'b0; Init = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("expose_hold", ctl(), C_EXP);
        end
        check("expose_initial_frozen", 8'(Initial), 8'd5);
        Ovf5 = 1'b1;
        tick();
        check("readout_r0", ctl(), ro_exp[0]);
        Ovf5 = 1'b0;
        for (int i = 1; i < 6; i++) begin
            tick();
            check($sformatf("readout_r%0d", i), ctl(), ro_exp[i]);
        end
        check("readout_initial_frozen", 8'(Initial), 8'd5);
        tick();
        check("back_idle", ctl(), C_IDLE);
        Init = 1'b0; Exp_increase = 1'b0;
        tick();
        check("idle_stays", ctl(), C_IDLE);

        // Reset abort at R1
        Init = 1'b1;
        tick();
        Init = 1'b0;
        tick();
        Ovf5 = 1'b1;
        tick();
        Ovf5 = 1'b0;
        tick();
        check("abort_at_r1", ctl(), ro_exp[1]);
        Reset = 1'b0;
        tick();
        check("abort_ctl", ctl(), C_IDLE);
        check("abort_initial", 8'(Initial), 8'd2);
        Reset = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("abort_quiet", ctl(), C_IDLE);
        end

        // Watchdog (or indefinite wait without it)
        Init = 1'b1;
        tick();
        Init = 1'b0;
        check("wd_start", ctl(), C_EXPS);
`ifdef EXPOSE_TIMEOUT_EN
        for (int i = 0; i < 39; i++) tick();
        check("wd_cycle40_expose", ctl(), C_EXP);
        tick();
        check("wd_timeout_r0", ctl(), ro_exp[0]);
`else
        for (int i = 0; i < 250; i++) tick();
        check("no_wd_still_expose", ctl(), C_EXP);
        Ovf5 = 1'b1;
        tick();
        Ovf5 = 1'b0;
        check("no_wd_ovf_r0", ctl(), ro_exp[0]);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
